mem_access_unit: RTL and testbench

- Initiator side of the byte-addressed, little-endian data-memory port: the CPU's load/store unit.
- Accepts one load/store request at a time through a valid/ready handshake.
- Drives word-aligned memory reads and writes. Performs read-modify-write for byte and halfword stores, because the memory only writes full words.
- Returns sign/zero-extended load data, or a fault, with a one-cycle response strobe.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access-size decoding.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   // Byte count touched by an access; 0 marks an illegal funct3.
   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: access_size = 3'd1;
         F3_H, F3_HU: access_size = 3'd2;
         F3_W:        access_size = 3'd4;
         default:     access_size = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the CPU: load
// extraction with sign/zero extension, and the merge used by SB/SH.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [31:0] shifted;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      shifted  = word >> {offset, 3'b000};
      byte_val = shifted[7:0];
      half_val = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
         F3_BU:   load_data = {24'd0, byte_val};
         F3_H:    load_data = {{16{half_val[15]}}, half_val};
         F3_HU:   load_data = {16'd0, half_val};
         default: load_data = word;
      endcase
   end

   // Only the addressed lane(s) change; the rest of the old word is kept.
   always_comb begin
      merged_word = word;
      case (funct3)
         F3_B:    merged_word[{offset, 3'b000} +: 8]      = wdata[7:0];
         F3_H:    merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged_word = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit: one request at a time, word-aligned memory cycles,
// read-modify-write for sub-word stores, one-cycle response strobe.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = 12,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_en,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   state_t      state;
   logic        write_q;
   logic [2:0]  funct3_q;
   logic [1:0]  offset_q;
   logic [31:0] wdata_q;
   logic [31:0] load_data;
   logic [31:0] merged_word;
   logic        req_fault;
   logic [2:0]  req_size;
   logic [ADDR_W:0] req_end;

   // The extra address bit keeps accesses near the top of the address
   // space from wrapping back into range.
   always_comb begin
      req_size  = access_size(req_funct3);
      req_end   = {1'b0, req_addr} + (ADDR_W+1)'(req_size);
      req_fault = (req_size == 3'd0) || (req_end > (ADDR_W+1)'(MEM_BYTES));
      case (req_funct3)
         F3_H, F3_HU: if (req_addr[0]) req_fault = 1'b1;
         F3_W:        if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
         default:     ;
      endcase
      if (req_write && (req_funct3 == F3_BU || req_funct3 == F3_HU))
         req_fault = 1'b1;
   end

   mem_lane_align u_lane_align (
      .word        (mem_read_data),
      .offset      (offset_q),
      .funct3      (funct3_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         write_q        <= 1'b0;
         funct3_q       <= 3'b000;
         offset_q       <= 2'b00;
         wdata_q        <= 32'd0;
         resp_valid     <= 1'b0;
         resp_rdata     <= 32'd0;
         resp_fault     <= 1'b0;
         mem_addr       <= '0;
         mem_write_en   <= 1'b0;
         mem_write_data <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  write_q   <= req_write;
                  funct3_q  <= req_funct3;
                  offset_q  <= req_addr[1:0];
                  wdata_q   <= req_wdata;
                  if (req_fault) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                     if (req_write && req_funct3 == F3_W) begin
                        state          <= WR;
                        mem_write_en   <= 1'b1;
                        mem_write_data <= req_wdata;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: begin
               if (write_q) begin
                  state          <= WR;
                  mem_write_en   <= 1'b1;
                  mem_write_data <= merged_word;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b0;
                  resp_rdata <= load_data;
               end
            end
            WR: begin
               state        <= RESP;
               mem_write_en <= 1'b0;
               resp_valid   <= 1'b1;
               resp_fault   <= 1'b0;
               resp_rdata   <= 32'd0;
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model
// attached to the memory port (MEM_BYTES = 10).
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [4];

   int passCount = 0;
   int checkCount = 0;
   int failCount = 0;

   int          respLat;
   int          wrCycles;
   logic [31:0] wrAddr;
   logic [31:0] wrData;
   logic [31:0] gotRdata;
   logic        gotFault;

   mem_access_unit #(.MEM_BYTES(10), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .mem_addr       (mem_addr),
      .mem_write_en   (mem_write_en),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: combinational read, write on the rising edge.
   assign mem_read_data = mem[mem_addr[3:2]];
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_addr[3:2]] <= mem_write_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic sendReq(input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("ready_before_req", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_funct3 = 3'b111;
      req_addr   = 32'hA5A5_A5A5;
      req_wdata  = 32'h5A5A_5A5A;
   endtask

   // Samples each cycle after the accept edge; cycle N+1 is k=1.
   task automatic waitResp;
      respLat  = 0;
      wrCycles = 0;
      wrAddr   = 32'hX;
      wrData   = 32'hX;
      for (int k = 1; k <= 8; k++) begin
         if (mem_write_en) begin
            wrCycles++;
            wrAddr = mem_addr;
            wrData = mem_write_data;
         end
         if (resp_valid) begin
            respLat  = k;
            gotRdata = resp_rdata;
            gotFault = resp_fault;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
      sendReq(wr, f3, addr, wdata);
      waitResp();
   endtask

   task automatic expectResp(input string tag, input logic [31:0] rdata,
                             input logic fault, input int lat, input int wrc);
      checkOutput({tag, "_lat"}, 32'(respLat), 32'(lat));
      checkOutput({tag, "_rdata"}, gotRdata, rdata);
      checkOutput({tag, "_fault"}, 32'(gotFault), 32'(fault));
      checkOutput({tag, "_wrcycles"}, 32'(wrCycles), 32'(wrc));
   endtask

   initial begin
      mem[0] = 32'h8877_6655;
      mem[1] = 32'h0000_0000;
      mem[2] = 32'h1122_3344;
      mem[3] = 32'h0000_0000;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
      checkOutput("rst_resp_fault", 32'(resp_fault), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_write_en), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_mem_wdata", mem_write_data, 32'd0);

      applyStimulus(1'b0, F3_B, 32'd3, 32'd0);
      expectResp("lb3", 32'hFFFF_FF88, 1'b0, 2, 0);
      applyStimulus(1'b0, F3_BU, 32'd3, 32'd0);
      expectResp("lbu3", 32'h0000_0088, 1'b0, 2, 0);
      applyStimulus(1'b0, F3_H, 32'd2, 32'd0);
      expectResp("lh2", 32'hFFFF_8877, 1'b0, 2, 0);
      applyStimulus(1'b0, F3_HU, 32'd0, 32'd0);
      expectResp("lhu0", 32'h0000_6655, 1'b0, 2, 0);

      applyStimulus(1'b1, F3_W, 32'd4, 32'hDEAD_BEEF);
      expectResp("sw4", 32'd0, 1'b0, 2, 1);
      checkOutput("sw4_addr", wrAddr, 32'd4);
      checkOutput("sw4_data", wrData, 32'hDEAD_BEEF);
      applyStimulus(1'b0, F3_W, 32'd4, 32'd0);
      expectResp("lw4", 32'hDEAD_BEEF, 1'b0, 2, 0);
      @(posedge clk);
      #1;
      checkOutput("lw4_strobe_drop", 32'(resp_valid), 32'd0);
      checkOutput("lw4_rdata_hold", resp_rdata, 32'hDEAD_BEEF);

      applyStimulus(1'b1, F3_B, 32'd1, 32'h0000_00AA);
      expectResp("sb1", 32'd0, 1'b0, 3, 1);
      checkOutput("sb1_addr", wrAddr, 32'd0);
      checkOutput("sb1_data", wrData, 32'h8877_AA55);
      checkOutput("sb1_mem", mem[0], 32'h8877_AA55);

      applyStimulus(1'b1, F3_W, 32'd0, 32'h8877_6655);
      expectResp("sw0_restore", 32'd0, 1'b0, 2, 1);
      applyStimulus(1'b1, F3_H, 32'd2, 32'hFFFF_1234);
      expectResp("sh2", 32'd0, 1'b0, 3, 1);
      checkOutput("sh2_data", wrData, 32'h1234_6655);

      applyStimulus(1'b0, F3_B, 32'd9, 32'd0);
      expectResp("lb9_edge", 32'h0000_0033, 1'b0, 2, 0);
      applyStimulus(1'b0, F3_B, 32'd10, 32'd0);
      expectResp("lb10_range", 32'd0, 1'b1, 1, 0);
      applyStimulus(1'b0, F3_H, 32'd1, 32'd0);
      expectResp("lh1_misalign", 32'd0, 1'b1, 1, 0);
      applyStimulus(1'b0, F3_W, 32'd2, 32'd0);
      expectResp("lw2_misalign", 32'd0, 1'b1, 1, 0);
      applyStimulus(1'b1, F3_W, 32'd8, 32'h0BAD_0BAD);
      expectResp("sw8_range", 32'd0, 1'b1, 1, 0);
      applyStimulus(1'b0, 3'b011, 32'd0, 32'd0);
      expectResp("f3_illegal", 32'd0, 1'b1, 1, 0);
      applyStimulus(1'b1, F3_BU, 32'd0, 32'd0);
      expectResp("sbu_illegal", 32'd0, 1'b1, 1, 0);
      applyStimulus(1'b0, F3_B, 32'hFFFF_FFFF, 32'd0);
      expectResp("lb_top_wrap", 32'd0, 1'b1, 1, 0);

      // Abort an SB while its write strobe is up.
      sendReq(1'b1, F3_B, 32'd0, 32'h0000_0077);
      @(posedge clk);
      #1;
      checkOutput("abort_in_wr", 32'(mem_write_en), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort_we_async", 32'(mem_write_en), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_mem_kept", mem[0], 32'h1234_6655);
      checkOutput("abort_ready", 32'(req_ready), 32'd1);
      applyStimulus(1'b0, F3_W, 32'd0, 32'd0);
      expectResp("lw0_after_abort", 32'h1234_6655, 1'b0, 2, 0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
